fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch front end of the Salaga-RV processor, sitting between the instruction memory port (`imem`) and the decode stage. It owns the program counter and drives the IMEM address. It captures returned instruction words into a small FIFO and presents them to decode with a valid/ready handshake. It also applies control-flow redirects from execute (JAL/JALR/taken branch) and detects the all-zero halt word.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `FIFO_DEPTH`, 2, instruction-buffer entries; power of two, ≥2
- `clk`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-low: `reset==0` at a posedge resets the block
- `op_inst_addr`  out  32  fetch PC to IMEM
- `ip_inst_valid`  in  1  IMEM word valid this cycle (combinational from address)
- `ip_inst_from_imem`  in  32  IMEM instruction word
- `ip_redirect`  in  1  execute requests PC change
- `ip_redirect_pc`  in  32  redirect target
- `op_inst_valid`  out  1  FIFO head valid to decode
- `ip_inst_ready`  in  1  decode accepts head
- `op_inst`  out  32  head instruction
- `op_inst_pc`  out  32  head PC
- `op_halt`  out  1  halt word fetched and FIFO drained

## Operation
- **State:**
  - `pc` (32b).
  - `halted` flag.
  - FIFO of {pc, inst} entries, with read/write pointers and count.
- **Pop.** `pop = op_inst_valid & ip_inst_ready`.
- **Push.** Push is enabled when `ip_inst_valid & !halted & (!full | pop)`.
  - Push word == 32'h0: do not enqueue; set `halted`; `pc` holds.
  - Push word ≠ 0: enqueue {pc, word}; `pc <= pc + 4`, wrapping modulo 2^32.
- **Stall.** `ip_inst_valid==0` or FIFO full without pop: `pc` holds and nothing is enqueued.
- **Redirect.** When `ip_redirect` is high it has priority over everything except reset.
  - `pc <= {ip_redirect_pc[31:2], 2'b00}`.
  - FIFO flushed (count 0).
  - `halted` cleared, because a wrong-path halt word is discarded.
  - Same-cycle push and pop are discarded. Decode also sees `ip_redirect` and squashes anything it accepted that cycle.
- **Halt output.** `op_halt = halted & FIFO empty`. It stays high until a redirect or reset.
- **Pop when empty.** Never occurs, because `op_inst_valid=0`.
- **Full with pop.** Push and pop occur in the same cycle; count is unchanged.
- **Output path.** `op_inst`, `op_inst_pc` and `op_inst_valid` come from the FIFO head.
  - There is no combinational path from `ip_inst_ready` or `ip_redirect` to any output.
  - `op_inst_addr` is driven directly from `pc`.

## Timing
- **Reset values:**
  - `op_inst_addr`=`RESET_PC`.
  - `op_inst_valid`=0, `op_inst`=0, `op_inst_pc`=0.
  - `op_halt`=0.
  - FIFO empty, `halted`=0.
- **Reset mid-operation.** Same result at the next posedge with `reset==0`, regardless of redirect or handshake activity.
- **Latency.** A word returned in cycle N (IMEM valid, push enabled) appears on `op_inst` with `op_inst_valid=1` in cycle N+1.
- **Throughput.** Sustained throughput is 1 instruction/cycle while decode is ready.
- **After reset release.** First fetch address is `RESET_PC` in the first non-reset cycle; first `op_inst_valid` follows one cycle later.
- **Redirect at cycle N.**
  - `op_inst_addr` equals the target in N+1.
  - `op_inst_valid=0` in N+1.
  - The first target instruction is valid in N+2.
- **Halt word fetched at cycle N with FIFO empty after pops.** `op_halt=1` in N+1.

## Structure
- **Shared package `salaga_pkg`:**
  - `XLEN`=32.
  - `HALT_INST`=32'h0000_0000.
  - `PC_STEP`=4.
  - Fetch-entry typedef {pc, inst}.
- **Sub-module `fetch_fifo`:**
  - Synchronous FIFO parameterized by width and depth.
  - Ports: push/pop/flush, full/empty, head.
  - Same clock and active-low synchronous reset.
- **Top level.** `fetch_unit` keeps `pc`, `halted`, and the push/redirect logic.

## Test plan
- **Straight-line fetch.**
  - Stimulus: IMEM at 0x0..0xC = 0x00100093, 0x00200113, 0x00308193, 0x0; ready=1.
  - Required: `op_inst_pc` 0x0, 0x4, 0x8 on consecutive cycles; `op_halt`=1 one cycle after the last pop; `op_inst_addr` stays at 0xC.
- **Backpressure.**
  - Stimulus: ready=0 for 4 cycles.
  - Required: FIFO fills to 2; `op_inst_addr` holds at 0x8; no entries lost; order 0x0, 0x4 then 0x8 after ready=1.
- **Redirect.**
  - Stimulus: `ip_redirect`=1 with target 0x0000_000E while FIFO is full.
  - Required: next cycle `op_inst_addr`=0xC and `op_inst_valid`=0; following cycle head pc=0xC.
- **IMEM stall.**
  - Stimulus: `ip_inst_valid`=0 for 3 cycles.
  - Required: `pc` constant; FIFO drains and `op_inst_valid` drops; fetch resumes at the same PC.
- **Wrong-path halt.**
  - Stimulus: halt word fetched, redirect to 0x4 in the next cycle.
  - Required: `halted` cleared; `op_halt` never asserts; fetch continues from 0x4.
- **Reset mid-stream.**
  - Stimulus: `reset`=0 for 1 cycle with FIFO full and a redirect pending.
  - Required: all outputs at reset values; `op_inst_addr`=`RESET_PC`.

Source files
------------

// File: rtl/salaga_pkg.sv
// Shared Salaga-RV definitions: datapath width, fetch constants and the
// {pc, inst} entry carried through the instruction buffer.
package salaga_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] HALT_INST = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Instruction addresses are always word aligned; drop the low two bits.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched instructions, with flush and a
// same-cycle push/pop path when full. Head reads as zero when empty.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // NOTE: the storage array has no reset; validity lives in count, and the
   // head is masked to zero while empty so nothing stale is ever visible.
   always_ff @(posedge clk) begin
      if (reset && !flush && do_push) mem[wr_ptr] <= wdata;
   end

   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Salaga-RV instruction fetch: owns the PC, buffers IMEM words for decode,
// applies execute redirects and stops fetching on the all-zero halt word.
module fetch_unit
   import salaga_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] op_inst_addr,
   input  logic            ip_inst_valid,
   input  logic [XLEN-1:0] ip_inst_from_imem,
   input  logic            ip_redirect,
   input  logic [XLEN-1:0] ip_redirect_pc,
   output logic            op_inst_valid,
   input  logic            ip_inst_ready,
   output logic [XLEN-1:0] op_inst,
   output logic [XLEN-1:0] op_inst_pc,
   output logic            op_halt
);

   logic [XLEN-1:0] pc;
   logic            halted;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push_en;
   logic            is_halt;
   fetch_entry_t    head;
   fetch_entry_t    wentry;

   assign pop     = op_inst_valid & ip_inst_ready;
   assign push_en = ip_inst_valid & ~halted & (~full | pop);
   assign is_halt = (ip_inst_from_imem == HALT_INST);
   assign wentry  = '{pc: pc, inst: ip_inst_from_imem};

   // Redirect drives flush, which outranks the push and pop of that cycle.
   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_en & ~is_halt),
      .pop   (pop),
      .flush (ip_redirect),
      .wdata (wentry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else if (ip_redirect) begin
         pc     <= align_pc(ip_redirect_pc);
         halted <= 1'b0;
      end else if (push_en) begin
         if (is_halt) halted <= 1'b1;
         else         pc     <= pc + PC_STEP;
      end
   end

   assign op_inst_addr  = pc;
   assign op_inst_valid = ~empty;
   assign op_inst       = head.inst;
   assign op_inst_pc    = head.pc;
   assign op_halt       = halted & empty;

endmodule
